// File: rtl/moving_average_decoder.sv
// moving_average_decoder: rebuilds the sample stream x[n] from a running
// DEPTH-sample window sum S[n] using D = S[n] - S[n-1] + x[n-DEPTH].
// History of reconstructed samples lives in a circular buffer; reads are
// forced to zero until DEPTH samples have been accepted (FILL state).
// Optional range check: define MOVING_AVERAGE_DECODER_CHECK_EN to add the
// sticky ovf output flagging reconstructed values that exceed DATA_W bits.
module moving_average_decoder #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int SUM_W  = DATA_W + $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ena,
    input  logic [SUM_W-1:0]  is,
    output logic [DATA_W-1:0] od,
    output logic              od_valid
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
    ,
    output logic              ovf
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FULL_CNT  = FILL_W'(DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [SUM_W-1:0]   prev_sum;
    logic [PTR_W-1:0]   wr_ptr;
    logic [FILL_W-1:0]  fill_cnt;
    logic [DATA_W-1:0]  hist [DEPTH];
    logic [DATA_W-1:0]  old;
    logic [SUM_W-1:0]   diff;

    // Oldest sample leaving the window, then the modular difference that recovers x[n]
    always_comb begin
        old  = '0;
        if (state == RUN) begin
            old = hist[wr_ptr];
        end
        diff = is - prev_sum + SUM_W'(old);
    end

    // History buffer: no reset, written with each accepted reconstructed sample
    always_ff @(posedge clk) begin
        if (ena) begin
            hist[wr_ptr] <= DATA_W'(diff);
        end
    end

    // Control state, pointers and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= FILL;
            prev_sum <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            od       <= '0;
            od_valid <= 1'b0;
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
            ovf      <= 1'b0;
`endif
        end else begin
            od_valid <= ena;
            if (ena) begin
                od       <= DATA_W'(diff);
                prev_sum <= is;
                wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
                if (|diff[SUM_W-1:DATA_W]) begin
                    ovf <= 1'b1;
                end
`endif
                case (state)
                    FILL: begin
                        if (fill_cnt == LAST_FILL) begin
                            fill_cnt <= FULL_CNT;
                            state    <= RUN;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        fill_cnt <= FULL_CNT;
                    end
                    default: begin
                        state <= FILL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_moving_average_decoder.sv
// Directed bench for moving_average_decoder: a DEPTH=4/DATA_W=8 instance for
// the short vector tests and a DEPTH=255/DATA_W=32 instance for the long run.
module tb_moving_average_decoder;

    logic        clk;
    logic        nrst;
    logic        ena1;
    logic [9:0]  is1;
    logic [7:0]  od1;
    logic        odv1;
    logic        ena2;
    logic [39:0] is2;
    logic [31:0] od2;
    logic        odv2;
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
    logic        ovf1;
    logic        ovf2;
`endif

    int errors = 0;
    int checks = 0;

    moving_average_decoder #(.DEPTH(4), .DATA_W(8)) dut_small (
        .clk      (clk),
        .nrst     (nrst),
        .ena      (ena1),
        .is       (is1),
        .od       (od1),
        .od_valid (odv1)
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
        ,
        .ovf      (ovf1)
`endif
    );

    moving_average_decoder #(.DEPTH(255), .DATA_W(32)) dut_big (
        .clk      (clk),
        .nrst     (nrst),
        .ena      (ena2),
        .is       (is2),
        .od       (od2),
        .od_valid (odv2)
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
        ,
        .ovf      (ovf2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive1(input logic e, input logic [9:0] s);
        @(negedge clk);
        ena1 = e;
        is1  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic e, input logic [39:0] s);
        @(negedge clk);
        ena2 = e;
        is2  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        ena1 = 1'b0;
        ena2 = 1'b0;
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    logic [9:0]  const_sums [8] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd4, 10'd4, 10'd4, 10'd4};
    logic [7:0]  gate_x     [6] = '{8'd5, 8'd0, 8'd7, 8'd3, 8'd9, 8'd2};
    logic [9:0]  gate_s     [6] = '{10'd5, 10'd5, 10'd12, 10'd15, 10'd19, 10'd21};
    logic [9:0]  sat_sums   [8] = '{10'd255, 10'd510, 10'd765, 10'd1020,
                                    10'd1020, 10'd1020, 10'd1020, 10'd1020};

    logic [31:0] win [255];
    logic [39:0] run_sum;
    logic [31:0] xv;

    initial begin
        nrst = 1'b0;
        ena1 = 1'b0;
        is1  = '0;
        ena2 = 1'b0;
        is2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_od", 64'(od1), 64'd0);
        check_val("reset_valid", 64'(odv1), 64'd0);
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
        check_val("reset_ovf", 64'(ovf1), 64'd0);
`endif
        @(negedge clk);
        nrst = 1'b1;

        // constant x=1, continuous ena, crosses FILL->RUN and pointer wrap
        for (int i = 0; i < 8; i++) begin
            drive1(1'b1, const_sums[i]);
            check_val("const_od", 64'(od1), 64'd1);
            check_val("const_valid", 64'(odv1), 64'd1);
        end
        drive1(1'b0, 10'd0);
        check_val("idle_valid", 64'(odv1), 64'd0);
        check_val("idle_hold", 64'(od1), 64'd1);

        // ena gated every other cycle; garbage on is while idle
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            drive1(1'b1, gate_s[i]);
            check_val("gate_od", 64'(od1), 64'(gate_x[i]));
            check_val("gate_valid", 64'(odv1), 64'd1);
            drive1(1'b0, 10'h3FF);
            check_val("gate_hold", 64'(od1), 64'(gate_x[i]));
            check_val("gate_novalid", 64'(odv1), 64'd0);
        end

        // asynchronous reset mid-stream, away from any clock edge
        drive1(1'b1, 10'd21);
        #2;
        nrst = 1'b0;
        #1;
        check_val("async_od", 64'(od1), 64'd0);
        check_val("async_valid", 64'(odv1), 64'd0);
        ena1 = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        drive1(1'b1, 10'd2);
        check_val("post_rst_od0", 64'(od1), 64'd2);
        drive1(1'b1, 10'd4);
        check_val("post_rst_od1", 64'(od1), 64'd2);

        // full-scale samples: sum saturates at 1020, wrap 3->0 twice
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            drive1(1'b1, sat_sums[i]);
            check_val("sat_od", 64'(od1), 64'd255);
        end
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
        check_val("sat_ovf", 64'(ovf1), 64'd0);
`endif

        // illegal sum: D=300 truncates to 44 and raises ovf
        pulse_reset();
        drive1(1'b1, 10'd0);
        check_val("ovf_first_od", 64'(od1), 64'd0);
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
        check_val("ovf_clear", 64'(ovf1), 64'd0);
`endif
        drive1(1'b1, 10'd300);
        check_val("ovf_od", 64'(od1), 64'd44);
        check_val("ovf_valid", 64'(odv1), 64'd1);
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
        check_val("ovf_set", 64'(ovf1), 64'd1);
        drive1(1'b0, 10'd0);
        check_val("ovf_sticky", 64'(ovf1), 64'd1);
`endif
        drive1(1'b0, 10'd0);

        // DEPTH=255: 300 samples of all-ones, then zeros; sums from a reference window
        pulse_reset();
        run_sum = '0;
        for (int k = 0; k < 255; k++) win[k] = '0;
        for (int n = 0; n < 320; n++) begin
            xv = (n < 300) ? 32'hFFFF_FFFF : 32'h0;
            run_sum = run_sum + 40'(xv) - 40'(win[n % 255]);
            win[n % 255] = xv;
            drive2(1'b1, run_sum);
            check_val("big_od", 64'(od2), 64'(xv));
            check_val("big_valid", 64'(odv2), 64'd1);
        end
`ifdef MOVING_AVERAGE_DECODER_CHECK_EN
        check_val("big_ovf", 64'(ovf2), 64'd0);
`endif
        drive2(1'b0, '0);
        check_val("big_idle_valid", 64'(odv2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
